card_digit_buffer: RTL and testbench

Upstream stage of the Luhn checker. Captures card digits one at a time from the digit switches on each press of the enter key and stores up to MAX_DIGITS of them. On a press of the start key it streams the stored digits, in entry order, to the Luhn checker over a valid/ready handshake. The end of the number is marked by a last flag.

---
 rtl/card_digit_buffer.sv | 145 ++++++++++++++
 tb/tb_card_digit_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_digit_buffer.sv
// card_digit_buffer
//   Captures BCD card digits from the switches on each enter-key press and
//   stores up to MAX_DIGITS of them in entry order. A start-key press streams
//   the stored digits to the Luhn checker over a valid/ready handshake, and
//   out_last marks the final digit.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   digit_in   BCD digit on the switches, sampled when the enter press acts
//   enter_n    raw active-low enter key
//   start_n    raw active-low start key
//   clear      synchronous clear pulse; empties the store, returns to COLLECT
//   out_digit  digit to the Luhn checker (0 when not valid)
//   out_valid  out_digit/out_last valid
//   out_last   current beat is the final stored digit
//   out_ready  Luhn checker accepts the current beat
//   count      number of digits stored
//   full       count == MAX_DIGITS
//   busy       streaming in progress
//   bad_digit  one-cycle pulse when an enter press carries a digit above 9
module card_digit_buffer #(
    parameter int unsigned MAX_DIGITS = 16,
    parameter int unsigned CW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    digit_in,
    input  logic          enter_n,
    input  logic          start_n,
    input  logic          clear,
    output logic [3:0]    out_digit,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          busy,
    output logic          bad_digit
);

    localparam int unsigned AW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STREAM  = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] rd_ptr;
    logic [3:0]    mem [MAX_DIGITS];

    // Key chains: bit 0 = s1, bit 1 = s2, bit 2 = s3. Released level is 1.
    logic [2:0] enter_sync;
    logic [2:0] start_sync;
    logic       enter_press;
    logic       start_press;
    logic       wr_en;

    // The falling-edge pulse is registered once more, so a key sampled low at
    // edge k acts at edge k+3 and digit_in is taken at that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_sync  <= '1;
            start_sync  <= '1;
            enter_press <= 1'b0;
            start_press <= 1'b0;
        end else begin
            enter_sync  <= {enter_sync[1:0], enter_n};
            start_sync  <= {start_sync[1:0], start_n};
            enter_press <= enter_sync[2] & ~enter_sync[1];
            start_press <= start_sync[2] & ~start_sync[1];
        end
    end

    always_comb begin
        full      = (count == CW'(MAX_DIGITS));
        busy      = (state == STREAM);
        out_valid = busy;
        out_last  = busy && (rd_ptr == count - CW'(1));
        // Gate the read so unwritten (never reset) slots are never visible.
        out_digit = busy ? mem[rd_ptr[AW-1:0]] : '0;
        wr_en     = (state == COLLECT) && enter_press && !clear && !full &&
                    (digit_in <= 4'd9);
    end

    // Digit store carries no reset; only count and pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[AW-1:0]] <= digit_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            count     <= '0;
            rd_ptr    <= '0;
            bad_digit <= 1'b0;
        end else begin
            bad_digit <= 1'b0;
            if (clear) begin
                state  <= COLLECT;
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                case (state)
                    COLLECT: begin
                        // A full store swallows presses without complaint.
                        if (enter_press && !full) begin
                            if (digit_in > 4'd9) begin
                                bad_digit <= 1'b1;
                            end else begin
                                count <= count + CW'(1);
                            end
                        end
                        if (start_press && (count != '0)) begin
                            rd_ptr <= '0;
                            state  <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (out_ready) begin
                            rd_ptr <= rd_ptr + CW'(1);
                            if (out_last) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (start_press) begin
                            rd_ptr <= '0;
                            state  <= STREAM;
                        end
                    end
                    default: begin
                        state <= COLLECT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_digit_buffer.sv
// tb_card_digit_buffer
//   Randomized and directed stimulus for card_digit_buffer, checked every
//   cycle against a queue-based behavioural model of the digit buffer.
module tb_card_digit_buffer;

    localparam int MAXD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit_in;
    logic       enter_n;
    logic       start_n;
    logic       clear;
    logic [3:0] out_digit;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       busy;
    logic       bad_digit;

    card_digit_buffer #(.MAX_DIGITS(16), .CW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_in  (digit_in),
        .enter_n   (enter_n),
        .start_n   (start_n),
        .clear     (clear),
        .out_digit (out_digit),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .busy      (busy),
        .bad_digit (bad_digit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 collecting, 1 streaming, 2 done. q holds the stored digits.
    int mode = 0;
    int q[$];
    int rd = 0;
    bit mbad = 1'b0;
    // Key sample history, index 0 = sample at the previous edge.
    bit eh[4] = '{1, 1, 1, 1};
    bit sh[4] = '{1, 1, 1, 1};

    always @(posedge clk) begin : model
        bit ep, sp;
        int old_n;
        if (reset) begin
            mode = 0;
            q.delete();
            rd   = 0;
            mbad = 1'b0;
            for (int i = 0; i < 4; i++) begin
                eh[i] = 1'b1;
                sh[i] = 1'b1;
            end
        end else begin
            // A press acts three edges after the first low sample.
            ep    = !eh[2] && eh[3];
            sp    = !sh[2] && sh[3];
            mbad  = 1'b0;
            old_n = q.size();
            if (clear) begin
                q.delete();
                mode = 0;
                rd   = 0;
            end else if (mode == 0) begin
                if (ep && old_n < MAXD) begin
                    if (digit_in > 9) mbad = 1'b1;
                    else              q.push_back(int'(digit_in));
                end
                if (sp && old_n > 0) begin
                    rd   = 0;
                    mode = 1;
                end
            end else if (mode == 1) begin
                if (out_ready) begin
                    if (rd == q.size() - 1) mode = 2;
                    rd++;
                end
            end else begin
                if (sp) begin
                    rd   = 0;
                    mode = 1;
                end
            end
            for (int i = 3; i > 0; i--) begin
                eh[i] = eh[i-1];
                sh[i] = sh[i-1];
            end
            eh[0] = enter_n;
            sh[0] = start_n;
        end
    end

    // ---------------- per-cycle compare and transfer log ----------------
    int xfer_log[$];
    int last_log[$];
    int bad_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_last", out_last, 0);
            check("rst_out_digit", out_digit, 0);
            check("rst_count", count, 0);
            check("rst_full", full, 0);
            check("rst_busy", busy, 0);
            check("rst_bad_digit", bad_digit, 0);
        end else begin
            check("out_valid", out_valid, (mode == 1));
            check("busy", busy, (mode == 1));
            check("count", count, q.size());
            check("full", full, (q.size() == MAXD));
            check("bad_digit", bad_digit, mbad);
            if (mode == 1) begin
                check("out_digit", out_digit, q[rd]);
                check("out_last", out_last, (rd == q.size() - 1));
            end
            if (out_valid && out_ready) begin
                xfer_log.push_back(int'(out_digit));
                last_log.push_back(int'(out_last));
            end
            if (bad_digit) bad_cnt++;
        end
    end

    // ---------------- out_ready driver ----------------
    // 0: always 1, 1: pattern 1,0,0,1, 2: random, 3: held 0
    int ready_mode = 0;
    initial begin : ready_drv
        int pi;
        bit pat[4];
        pat = '{1, 0, 0, 1};
        pi  = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[pi % 4]; pi++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input int d);
        digit_in = 4'(d);
        enter_n  = 1'b0;
        repeat (5) tick();
        enter_n  = 1'b1;
        repeat (2) tick();
    endtask

    task automatic press_start();
        start_n = 1'b0;
        repeat (5) tick();
        start_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic wait_stream_done();
        int n;
        n = 0;
        while ((busy || mode == 1) && n < 400) begin
            tick();
            n++;
        end
        check("stream_done_in_budget", (n < 400), 1);
    endtask

    task automatic check_log_against(input int exp[$], input string name);
        check({name, "_len"}, xfer_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xfer_log.size(); i++) begin
            check(name, xfer_log[i], exp[i]);
        end
    endtask

    int card[$] = '{4, 9, 9, 2, 7, 3, 9, 8, 7, 1, 6, 8, 8, 8, 8, 7};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lasts;
        int exp_q[$];
        reset    = 1'b1;
        digit_in = 4'd0;
        enter_n  = 1'b1;
        start_n  = 1'b1;
        clear    = 1'b0;
        repeat (3) tick();
        check("reset_count", count, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Full card, streamed with out_ready held high.
        ready_mode = 0;
        foreach (card[i]) press_enter(card[i]);
        check("full_after_16", full, 1);
        check("count_after_16", count, 16);
        press_enter(5);
        check("count_17th_ignored", count, 16);
        check("bad_17th", bad_cnt, 0);

        xfer_log.delete();
        last_log.delete();
        start_n = 1'b0;
        repeat (3) tick();
        check("start_latency_busy_early", busy, 0);
        tick();
        check("start_latency_busy", busy, 1);
        check("start_latency_valid", out_valid, 1);
        check("start_first_digit", out_digit, 4);
        tick();
        start_n = 1'b1;
        wait_stream_done();
        check_log_against(card, "stream_ready_high");
        lasts = 0;
        foreach (last_log[i]) lasts += last_log[i];
        check("last_count", lasts, 1);
        if (last_log.size() == 16) check("last_on_16th", last_log[15], 1);
        check("done_valid_low", out_valid, 0);
        check("done_count_kept", count, 16);

        // Enter in DONE is ignored; replay with a stalling consumer.
        press_enter(3);
        check("done_enter_ignored", count, 16);
        ready_mode = 1;
        xfer_log.delete();
        press_start();
        wait_stream_done();
        check_log_against(card, "stream_stall");
        ready_mode = 0;

        // Invalid digit on an empty buffer, then a start that must be ignored.
        pulse_clear();
        bad_cnt = 0;
        press_enter(12);
        check("bad_pulse_once", bad_cnt, 1);
        check("bad_count_zero", count, 0);
        press_start();
        check("empty_start_busy", busy, 0);

        // Clear after the second transfer of 1,2,3.
        press_enter(1);
        press_enter(2);
        press_enter(3);
        xfer_log.delete();
        start_n = 1'b0;
        begin : wait_two
            int n;
            n = 0;
            while (xfer_log.size() < 2 && n < 50) begin
                tick();
                n++;
            end
            check("two_xfers_in_budget", (n < 50), 1);
        end
        start_n = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_valid", out_valid, 0);
        check("clear_count", count, 0);
        check("clear_busy", busy, 0);
        tick();
        press_enter(6);
        xfer_log.delete();
        press_start();
        wait_stream_done();
        exp_q = '{6};
        check_log_against(exp_q, "after_clear_index0");

        // Reset in mid-stream with start held low.
        pulse_clear();
        press_enter(5);
        press_enter(5);
        ready_mode = 3;
        start_n = 1'b0;
        repeat (5) tick();
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_count", count, 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (8) tick();
        check("post_reset_busy", busy, 0);
        check("post_reset_count", count, 0);
        start_n = 1'b1;
        repeat (2) tick();
        press_start();
        check("post_reset_start_ignored", busy, 0);
        ready_mode = 0;

        // Randomized rounds checked against the model.
        for (int r = 0; r < 25; r++) begin
            int n;
            pulse_clear();
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) press_enter($urandom_range(10, 15));
                else                            press_enter($urandom_range(0, 9));
            end
            for (int rep = 0; rep < 2; rep++) begin
                ready_mode = $urandom_range(0, 2);
                xfer_log.delete();
                exp_q = q;
                press_start();
                wait_stream_done();
                check_log_against(exp_q, "rand_stream");
                if ($urandom_range(0, 1) == 0) break;
            end
            ready_mode = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
